// File: rtl/pwm_ctrl_pkg.sv
// Shared state encoding and default parameters for the PWM speed sequencer.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  localparam int unsigned DEF_PWM_W      = 8;
  localparam int unsigned DEF_START_DUTY = 64;
  localparam int unsigned DEF_STEP       = 16;
  localparam int unsigned DEF_RAMP_DIV   = 1024;

endpackage

// File: rtl/btn_sync_edge.sv
// Push-button conditioner: 2-FF synchroniser plus single-cycle rising-edge pulse.
// A button already held when reset releases stays disarmed until it is seen low,
// so presses in flight across reset never produce an event.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise_c
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic       armed;
  logic [1:0] vld;

  // Synchroniser, edge history and post-reset arming
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      armed <= 1'b0;
      vld   <= 2'b00;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      vld   <= {vld[0], 1'b1};
      armed <= armed | (vld[1] & ~sync2);
    end
  end

  assign rise_c = armed & sync2 & ~prev;

endmodule

// File: rtl/pwm_speed_ctrl.sv
// Button-driven motor speed sequencer: target/ramp FSM with slew-limited duty
// and a glitch-free shadowed PWM generator.
module pwm_speed_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned PWM_W      = DEF_PWM_W,
  parameter int unsigned START_DUTY = DEF_START_DUTY,
  parameter int unsigned STEP       = DEF_STEP,
  parameter int unsigned RAMP_DIV   = DEF_RAMP_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic             btn_increase,
  input  logic             btn_decrease,
  output logic             motor_pwm,
  output logic             motor_running,
  output logic [PWM_W-1:0] duty_target,
  output logic [PWM_W-1:0] duty_current,
  output logic             ramping
);

  localparam int unsigned      PRESC_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PWM_W-1:0] MAX_DUTY   = {PWM_W{1'b1}};
  localparam logic [PWM_W:0]   STEP_X     = (PWM_W+1)'(STEP);
  localparam logic [PWM_W-1:0] START_D    = PWM_W'(START_DUTY);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RAMP_DIV - 1);

  logic ev_start;
  logic ev_stop;
  logic ev_inc;
  logic ev_dec;

  state_t             state;
  state_t             state_nxt;
  logic [PWM_W-1:0]   target_nxt;
  logic [PWM_W-1:0]   current_nxt;
  logic [PRESC_W-1:0] presc;
  logic               tick_c;
  logic [PWM_W:0]     inc_sum;
  logic [PWM_W-1:0]   inc_val;
  logic [PWM_W-1:0]   dec_val;
  logic [PWM_W-1:0]   pwm_cnt;
  logic [PWM_W-1:0]   pwm_shadow;

  btn_sync_edge u_start (.clk(clk), .rst(rst), .btn(btn_start),    .rise_c(ev_start));
  btn_sync_edge u_stop  (.clk(clk), .rst(rst), .btn(btn_stop),     .rise_c(ev_stop));
  btn_sync_edge u_inc   (.clk(clk), .rst(rst), .btn(btn_increase), .rise_c(ev_inc));
  btn_sync_edge u_dec   (.clk(clk), .rst(rst), .btn(btn_decrease), .rise_c(ev_dec));

  assign tick_c = ((state == ST_RAMP) || (state == ST_STOP)) && (presc == PRESC_LAST);

  // Saturating target arithmetic, computed one bit wider so increase cannot wrap
  always_comb begin
    inc_sum = {1'b0, duty_target} + STEP_X;
    inc_val = (inc_sum > {1'b0, MAX_DUTY}) ? MAX_DUTY : inc_sum[PWM_W-1:0];
    dec_val = ({1'b0, duty_target} < STEP_X) ? '0 : PWM_W'({1'b0, duty_target} - STEP_X);
  end

  // Next state, next target and next applied duty (stop > start > inc/dec)
  always_comb begin
    state_nxt   = state;
    target_nxt  = duty_target;
    current_nxt = duty_current;

    if (tick_c) begin
      if (duty_current < duty_target) begin
        current_nxt = duty_current + PWM_W'(1);
      end else if (duty_current > duty_target) begin
        current_nxt = duty_current - PWM_W'(1);
      end
    end

    case (state)
      ST_IDLE: begin
        if (ev_start && !ev_stop) begin
          state_nxt  = ST_RAMP;
          target_nxt = START_D;
        end
      end
      ST_RAMP, ST_RUN: begin
        if (ev_stop) begin
          state_nxt  = ST_STOP;
          target_nxt = '0;
        end else begin
          if (!ev_start && (ev_inc ^ ev_dec)) begin
            target_nxt = ev_inc ? inc_val : dec_val;
          end
          state_nxt = (current_nxt == target_nxt) ? ST_RUN : ST_RAMP;
        end
      end
      ST_STOP: begin
        if (current_nxt == '0) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, duty registers and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      duty_target   <= '0;
      duty_current  <= '0;
      motor_running <= 1'b0;
      ramping       <= 1'b0;
    end else begin
      state         <= state_nxt;
      duty_target   <= target_nxt;
      duty_current  <= current_nxt;
      motor_running <= (state_nxt != ST_IDLE);
      ramping       <= (state_nxt == ST_RAMP) || (state_nxt == ST_STOP);
    end
  end

  // Ramp prescaler: runs only while ramping, keeps its phase across redirects
  always_ff @(posedge clk) begin
    if (rst || !((state == ST_RAMP) || (state == ST_STOP))) begin
      presc <= '0;
    end else if (tick_c) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  // PWM counter, shadow duty reloaded at wrap, registered comparator output
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt    <= '0;
      pwm_shadow <= '0;
      motor_pwm  <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + PWM_W'(1);
      motor_pwm <= (pwm_cnt < pwm_shadow);
      if (pwm_cnt == MAX_DUTY) begin
        pwm_shadow <= duty_current;
      end
    end
  end

endmodule

// File: tb/tb_pwm_speed_ctrl.sv
// Directed bench for pwm_speed_ctrl: vector tables plus hand-timed sequences.
module tb_pwm_speed_ctrl;

  localparam int unsigned PWM_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             btn_start;
  logic             btn_stop;
  logic             btn_increase;
  logic             btn_decrease;
  logic             motor_pwm;
  logic             motor_running;
  logic [PWM_W-1:0] duty_target;
  logic [PWM_W-1:0] duty_current;
  logic             ramping;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic  start;
    logic  stop;
    logic  inc;
    logic  dec;
    int    hold;
    int    wait_c;
    int    tgt;
    int    cur;
    logic  run;
    logic  rmp;
    int    pwm_hi;
    string name;
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];
  vec_t tab_c[$];

  pwm_speed_ctrl #(
    .PWM_W(PWM_W), .START_DUTY(8), .STEP(4), .RAMP_DIV(2)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_increase(btn_increase), .btn_decrease(btn_decrease),
    .motor_pwm(motor_pwm), .motor_running(motor_running),
    .duty_target(duty_target), .duty_current(duty_current),
    .ramping(ramping)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pwm_count(input string name, input int exp);
    int hi;
    hi = 0;
    cyc(32);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (motor_pwm) hi++;
    end
    chk(name, hi, exp);
  endtask

  function automatic vec_t mk(input logic s, input logic p, input logic i, input logic d,
                              input int h, input int w, input int tg, input int cu,
                              input logic ru, input logic ra, input int ph, input string nm);
    vec_t v;
    v.start = s; v.stop = p; v.inc = i; v.dec = d;
    v.hold = h; v.wait_c = w; v.tgt = tg; v.cur = cu;
    v.run = ru; v.rmp = ra; v.pwm_hi = ph; v.name = nm;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    btn_start = v.start; btn_stop = v.stop; btn_increase = v.inc; btn_decrease = v.dec;
    cyc(v.hold);
    btn_start = 1'b0; btn_stop = 1'b0; btn_increase = 1'b0; btn_decrease = 1'b0;
    cyc(v.wait_c);
    chk({v.name, " target"},  int'(duty_target),   v.tgt);
    chk({v.name, " current"}, int'(duty_current),  v.cur);
    chk({v.name, " running"}, int'(motor_running), int'(v.run));
    chk({v.name, " ramping"}, int'(ramping),       int'(v.rmp));
    if (v.pwm_hi >= 0) pwm_count({v.name, " pwm"}, v.pwm_hi);
  endtask

  initial begin
    //            st st in de hold wait tgt cur run rmp pwm  name
    tab_a.push_back(mk(0, 0, 1, 0, 1, 30, 12, 12, 1, 0, -1, "inc_12"));
    tab_a.push_back(mk(0, 0, 1, 0, 1, 30, 15, 15, 1, 0, 15, "inc_15"));
    tab_a.push_back(mk(0, 0, 1, 0, 1, 30, 15, 15, 1, 0, -1, "inc_sat"));
    tab_a.push_back(mk(0, 0, 1, 1, 1, 30, 15, 15, 1, 0, -1, "inc_dec_same"));
    tab_a.push_back(mk(0, 0, 0, 1, 1, 30, 11, 11, 1, 0, -1, "dec_11"));
    tab_a.push_back(mk(0, 0, 0, 1, 1, 30,  7,  7, 1, 0, -1, "dec_7"));
    tab_a.push_back(mk(0, 0, 0, 1, 1, 30,  3,  3, 1, 0, -1, "dec_3"));
    tab_a.push_back(mk(0, 0, 0, 1, 1, 30,  0,  0, 1, 0, -1, "dec_0"));
    tab_a.push_back(mk(0, 0, 0, 1, 1, 30,  0,  0, 1, 0,  0, "dec_sat0"));

    tab_b.push_back(mk(0, 0, 1, 0, 1, 30,  4,  4, 1, 0, -1, "inc_4"));
    tab_b.push_back(mk(0, 0, 1, 0, 1, 30,  8,  8, 1, 0,  8, "inc_8"));

    tab_c.push_back(mk(0, 0, 1, 0, 1, 10,  0,  0, 0, 0, -1, "inc_in_idle"));
    tab_c.push_back(mk(0, 0, 0, 1, 1, 10,  0,  0, 0, 0, -1, "dec_in_idle"));
    tab_c.push_back(mk(1, 0, 0, 0, 1, 30,  8,  8, 1, 0, -1, "restart"));
    tab_c.push_back(mk(1, 0, 0, 0, 1, 30,  8,  8, 1, 0, -1, "start_in_run"));
    tab_c.push_back(mk(0, 0, 1, 0, 50, 30, 12, 12, 1, 0, -1, "held_inc"));
    tab_c.push_back(mk(0, 1, 0, 0, 1,  5,  0, 11, 1, 1, -1, "stop_mid"));
    tab_c.push_back(mk(1, 0, 0, 0, 1, 40,  0,  0, 0, 0,  0, "start_in_stop"));

    rst = 1'b1;
    btn_start = 1'b0; btn_stop = 1'b0; btn_increase = 1'b0; btn_decrease = 1'b0;
    cyc(3);
    chk("reset target",  int'(duty_target),   0);
    chk("reset current", int'(duty_current),  0);
    chk("reset running", int'(motor_running), 0);
    chk("reset ramping", int'(ramping),       0);
    chk("reset pwm",     int'(motor_pwm),     0);
    rst = 1'b0;
    cyc(5);

    // Start ramp: event at k+2, one LSB every two cycles, RUN at k+18
    btn_start = 1'b1;
    for (int m = 0; m <= 18; m++) begin
      @(negedge clk);
      if (m == 4) btn_start = 1'b0;
      if (m < 2) begin
        chk($sformatf("start_early_run m%0d", m), int'(motor_running), 0);
      end else begin
        chk($sformatf("start_run m%0d", m),  int'(motor_running), 1);
        chk($sformatf("start_tgt m%0d", m),  int'(duty_target), 8);
        chk($sformatf("start_cur m%0d", m),  int'(duty_current), (m - 2) / 2);
        chk($sformatf("start_rmp m%0d", m),  int'(ramping), (m < 18) ? 1 : 0);
      end
    end
    pwm_count("start_pwm", 8);

    foreach (tab_a[i]) apply(tab_a[i]);
    foreach (tab_b[i]) apply(tab_b[i]);

    // Stop and increase together from RUN at 8: stop wins, ramp down to IDLE
    btn_stop = 1'b1; btn_increase = 1'b1;
    for (int m = 0; m <= 18; m++) begin
      @(negedge clk);
      if (m == 0) begin
        btn_stop = 1'b0; btn_increase = 1'b0;
      end
      if (m < 2) begin
        chk($sformatf("stopinc_early_tgt m%0d", m), int'(duty_target), 8);
      end else begin
        chk($sformatf("stopinc_tgt m%0d", m), int'(duty_target), 0);
        chk($sformatf("stopinc_cur m%0d", m), int'(duty_current), 8 - (m - 2) / 2);
        chk($sformatf("stopinc_run m%0d", m), int'(motor_running), (m < 18) ? 1 : 0);
        chk($sformatf("stopinc_rmp m%0d", m), int'(ramping), (m < 18) ? 1 : 0);
      end
    end

    foreach (tab_c[i]) apply(tab_c[i]);

    // Reset mid-ramp with start held through reset release
    btn_start = 1'b1;
    cyc(13);
    chk("rst_mid cur_before", int'(duty_current), 5);
    rst = 1'b1;
    cyc(1);
    chk("rst_mid target",  int'(duty_target),   0);
    chk("rst_mid current", int'(duty_current),  0);
    chk("rst_mid running", int'(motor_running), 0);
    chk("rst_mid ramping", int'(ramping),       0);
    chk("rst_mid pwm",     int'(motor_pwm),     0);
    cyc(2);
    rst = 1'b0;
    cyc(20);
    chk("held_through_rst running", int'(motor_running), 0);
    chk("held_through_rst target",  int'(duty_target),   0);
    btn_start = 1'b0;
    cyc(5);
    chk("release running", int'(motor_running), 0);
    btn_start = 1'b1;
    cyc(1);
    btn_start = 1'b0;
    cyc(1);
    chk("repress early running", int'(motor_running), 0);
    cyc(1);
    chk("repress running", int'(motor_running), 1);
    chk("repress target",  int'(duty_target),   8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
